// File: rtl/sync_debounce.sv
// ---------------------------------------------------------------------------
// sync_debounce
//   Multi-channel single-clock input conditioner. Each channel takes an
//   asynchronous pin and passes it through a synchroniser chain and then
//   a debounce filter. Each channel produces:
//   - a clean level,
//   - one-cycle rise/fall strobes,
//   - a sticky pending flag that software clears with ack.
//
// Parameters
//   CHANNELS     number of independent channels (>= 1)
//   SYNC_STAGES  synchroniser flops per channel (>= 2)
//   DEBOUNCE     consecutive disagreeing cycles needed to change level;
//                0 bypasses the filter (level follows the synchroniser)
//   INIT         reset value of the synchroniser chain and of level
//
// Ports
//   clk      in   1         single clock, all logic on posedge
//   reset    in   1         synchronous, active-high
//   in       in   CHANNELS  asynchronous raw inputs
//   ack      in   CHANNELS  per-channel clear of pending (one-cycle pulse)
//   level    out  CHANNELS  debounced level
//   rise     out  CHANNELS  one-cycle strobe, level went 0->1
//   fall     out  CHANNELS  one-cycle strobe, level went 1->0
//   pending  out  CHANNELS  sticky, an edge occurred since the last ack
//   irq      out  1         OR of pending
// ---------------------------------------------------------------------------
module sync_debounce #(
  parameter int                  CHANNELS    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  DEBOUNCE    = 16,
  parameter logic [CHANNELS-1:0] INIT        = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] ack,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] pending,
  output logic                irq
);

  logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_s;
  logic [CHANNELS-1:0] upd_s;
  logic [CHANNELS-1:0] level_r;
  logic [CHANNELS-1:0] rise_r;
  logic [CHANNELS-1:0] fall_r;
  logic [CHANNELS-1:0] pending_r;

  // Synchroniser shift chain: stage 0 samples the raw pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= INIT;
      end
    end else begin
      sync_r[0] <= in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // upd_s[ch] marks the edge on which level[ch] takes the synchronised value.
  generate
    if (DEBOUNCE == 0) begin : g_bypass
      assign upd_s = sync_s ^ level_r;
    end else begin : g_filter
      localparam int             CNT_W   = $clog2(DEBOUNCE + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

      for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_r;

        // Count consecutive disagreeing cycles. Clear on agreement.
        // Also clear on the flip itself, so the counter never wraps.
        always_ff @(posedge clk) begin
          if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (sync_s[g] == level_r[g]) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (cnt_r == CNT_MAX) begin
            cnt_r <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        assign upd_s[g] = (sync_s[g] != level_r[g]) && (cnt_r == CNT_MAX);
      end
    end
  endgenerate

  // Level, direction strobes and sticky pending.
  // A new edge beats a simultaneous ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r   <= INIT;
      rise_r    <= {CHANNELS{1'b0}};
      fall_r    <= {CHANNELS{1'b0}};
      pending_r <= {CHANNELS{1'b0}};
    end else begin
      level_r   <= (level_r & ~upd_s) | (sync_s & upd_s);
      rise_r    <= upd_s & sync_s;
      fall_r    <= upd_s & ~sync_s;
      pending_r <= (pending_r & ~ack) | upd_s;
    end
  end

  assign level   = level_r;
  assign rise    = rise_r;
  assign fall    = fall_r;
  assign pending = pending_r;
  assign irq     = |pending_r;

endmodule

// File: tb/tb_sync_debounce.sv
// ---------------------------------------------------------------------------
// tb_sync_debounce
//   Self-checking bench with two instances:
//   - dut_a uses the default configuration (SYNC_STAGES=2, DEBOUNCE=16).
//   - dut_b is a bypass configuration (SYNC_STAGES=3, DEBOUNCE=0).
//   The reference model keeps the history of raw samples since reset.
//   A channel's level flips when the synchronised value, which is the raw
//   sample from SYNC_STAGES edges earlier, has disagreed with level on each
//   of the last DEBOUNCE edges since the previous flip.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sync_debounce;

  localparam int SA   = 2;
  localparam int DA   = 16;
  localparam int SB   = 3;
  localparam int DB   = 0;
  localparam int HMAX = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_a, ack_a, level_a, rise_a, fall_a, pending_a;
  logic [3:0] in_b, ack_b, level_b, rise_b, fall_b, pending_b;
  logic       irq_a, irq_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_debounce #(.CHANNELS(4), .SYNC_STAGES(SA), .DEBOUNCE(DA), .INIT(4'b0000)) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .ack(ack_a), .level(level_a),
    .rise(rise_a), .fall(fall_a), .pending(pending_a), .irq(irq_a));

  sync_debounce #(.CHANNELS(4), .SYNC_STAGES(SB), .DEBOUNCE(DB), .INIT(4'b0000)) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .ack(ack_b), .level(level_b),
    .rise(rise_b), .fall(fall_b), .pending(pending_b), .irq(irq_b));

  // ---------------- reference model ----------------
  logic [3:0] hist [2][HMAX];
  int         nedge [2];
  int         last_upd [2][4];
  logic [3:0] m_level [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  logic [3:0] m_pend [2];

  // Synchronised value seen on edge m: the raw sample from SYNC_STAGES edges before.
  function automatic logic [3:0] s_at(input int i, input int m);
    int st;
    st = (i == 0) ? SA : SB;
    if ((m - st >= 1) && (m - st - 1 < HMAX)) return hist[i][m-st-1];
    return 4'b0000;
  endfunction

  // Advance the model of both instances on every clock edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0] raw, ak, upd, s_now, s_old;
      int         nn, db;
      raw = (i == 0) ? in_a : in_b;
      ak  = (i == 0) ? ack_a : ack_b;
      db  = (i == 0) ? DA : DB;
      if (reset) begin
        nedge[i]   <= 0;
        m_level[i] <= 4'b0000;
        m_rise[i]  <= 4'b0000;
        m_fall[i]  <= 4'b0000;
        m_pend[i]  <= 4'b0000;
        for (int c = 0; c < 4; c++) last_upd[i][c] <= 0;
      end else begin
        nn = nedge[i] + 1;
        if (nn <= HMAX) hist[i][nn-1] <= raw;
        s_now = s_at(i, nn);
        upd   = 4'b0000;
        for (int c = 0; c < 4; c++) begin
          if (db == 0) begin
            upd[c] = (s_now[c] != m_level[i][c]);
          end else if (nn - last_upd[i][c] >= db) begin
            upd[c] = 1'b1;
            for (int k = 0; k < db; k++) begin
              s_old = s_at(i, nn - k);
              if (s_old[c] == m_level[i][c]) upd[c] = 1'b0;
            end
          end
          if (upd[c]) last_upd[i][c] <= nn;
        end
        nedge[i]   <= nn;
        m_level[i] <= (m_level[i] & ~upd) | (s_now & upd);
        m_rise[i]  <= upd & s_now;
        m_fall[i]  <= upd & ~s_now;
        m_pend[i]  <= (m_pend[i] & ~ak) | upd;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; in_a = 4'b0001; ack_a = 4'b0000; in_b = 4'b0000; ack_b = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({level_a, rise_a, fall_a, pending_a, irq_a} !== 17'h0) begin
      errors++; $display("FAIL reset_a got=%h want=0", {level_a, rise_a, fall_a, pending_a, irq_a});
    end
    checks++;
    if ({level_b, rise_b, fall_b, pending_b, irq_b} !== 17'h0) begin
      errors++; $display("FAIL reset_b got=%h want=0", {level_b, rise_b, fall_b, pending_b, irq_b});
    end
  endtask

  task automatic test_init_edge();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if ({level_a, rise_a, fall_a, pending_a, irq_a} !== {m_level[0], m_rise[0], m_fall[0], m_pend[0], |m_pend[0]}) begin
        errors++; $display("FAIL init_model k=%0d got=%h want=%h", k, {level_a, rise_a, fall_a, pending_a, irq_a}, {m_level[0], m_rise[0], m_fall[0], m_pend[0], |m_pend[0]});
      end
      checks++;
      if (level_a[0] !== (k >= 18) || rise_a[0] !== (k == 18)) begin
        errors++; $display("FAIL init_level k=%0d got level=%b rise=%b want level=%b rise=%b", k, level_a[0], rise_a[0], k >= 18, k == 18);
      end
    end
    checks++;
    if (pending_a[0] !== 1'b1 || irq_a !== 1'b1) begin
      errors++; $display("FAIL init_pending got pend=%b irq=%b want 1 1", pending_a[0], irq_a);
    end
    ack_a = 4'b1111;
    @(negedge clk);
    ack_a = 4'b0000;
    checks++;
    if (pending_a !== 4'b0000 || irq_a !== 1'b0) begin
      errors++; $display("FAIL init_ack got pend=%b irq=%b want 0000 0", pending_a, irq_a);
    end
  endtask

  task automatic test_short_pulse();
    for (int k = 1; k <= 40; k++) begin
      in_a[1] = (k <= 15);
      @(negedge clk);
      checks++;
      if (level_a[1] !== 1'b0 || pending_a[1] !== 1'b0 || rise_a[1] !== 1'b0) begin
        errors++; $display("FAIL short15 k=%0d got level=%b pend=%b rise=%b want 0 0 0", k, level_a[1], pending_a[1], rise_a[1]);
      end
    end
    for (int k = 1; k <= 40; k++) begin
      in_a[1] = (k <= 16);
      @(negedge clk);
      checks++;
      if ({level_a, rise_a, fall_a, pending_a, irq_a} !== {m_level[0], m_rise[0], m_fall[0], m_pend[0], |m_pend[0]}) begin
        errors++; $display("FAIL short16_model k=%0d got=%h want=%h", k, {level_a, rise_a, fall_a, pending_a, irq_a}, {m_level[0], m_rise[0], m_fall[0], m_pend[0], |m_pend[0]});
      end
      checks++;
      if (level_a[1] !== (k >= 18 && k < 34) || rise_a[1] !== (k == 18)) begin
        errors++; $display("FAIL short16 k=%0d got level=%b rise=%b want level=%b rise=%b", k, level_a[1], rise_a[1], k >= 18 && k < 34, k == 18);
      end
    end
    ack_a = 4'b1111;
    @(negedge clk);
    ack_a = 4'b0000;
  endtask

  task automatic test_bounce();
    int nr, nf, rise_at;
    nr = 0; nf = 0; rise_at = -1;
    for (int k = 0; k < 140; k++) begin
      in_a[2] = (k >= 100) || (((k / 5) % 2) == 0);
      @(negedge clk);
      checks++;
      if ({level_a, rise_a, fall_a, pending_a, irq_a} !== {m_level[0], m_rise[0], m_fall[0], m_pend[0], |m_pend[0]}) begin
        errors++; $display("FAIL bounce_model k=%0d got=%h want=%h", k, {level_a, rise_a, fall_a, pending_a, irq_a}, {m_level[0], m_rise[0], m_fall[0], m_pend[0], |m_pend[0]});
      end
      if (rise_a[2]) begin nr++; rise_at = k; end
      if (fall_a[2]) nf++;
    end
    checks++;
    if (nr != 1 || nf != 0 || rise_at != 117) begin
      errors++; $display("FAIL bounce got rises=%0d falls=%0d at=%0d want 1 0 117", nr, nf, rise_at);
    end
    ack_a = 4'b1111;
    @(negedge clk);
    ack_a = 4'b0000;
  endtask

  task automatic test_ack_same_cycle();
    in_a[3] = 1'b1;
    repeat (20) @(negedge clk);
    ack_a = 4'b1111;
    @(negedge clk);
    ack_a = 4'b0000;
    in_a[3] = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      ack_a = (k >= 18) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      checks++;
      if ({level_a, rise_a, fall_a, pending_a, irq_a} !== {m_level[0], m_rise[0], m_fall[0], m_pend[0], |m_pend[0]}) begin
        errors++; $display("FAIL ack_model k=%0d got=%h want=%h", k, {level_a, rise_a, fall_a, pending_a, irq_a}, {m_level[0], m_rise[0], m_fall[0], m_pend[0], |m_pend[0]});
      end
      if (k == 18) begin
        checks++;
        if (fall_a[3] !== 1'b1 || pending_a[3] !== 1'b1) begin
          errors++; $display("FAIL ack_same got fall=%b pend=%b want 1 1", fall_a[3], pending_a[3]);
        end
      end
      if (k == 19) begin
        checks++;
        if (pending_a[3] !== 1'b0 || irq_a !== 1'b0 || fall_a[3] !== 1'b0) begin
          errors++; $display("FAIL ack_next got pend=%b irq=%b fall=%b want 0 0 0", pending_a[3], irq_a, fall_a[3]);
        end
      end
    end
    ack_a = 4'b0000;
  endtask

  task automatic test_reset_midway();
    in_a = 4'b0000;
    repeat (40) @(negedge clk);
    ack_a = 4'b1111;
    @(negedge clk);
    ack_a = 4'b0000;
    in_a[0] = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (level_a[0] !== 1'b0) begin
      errors++; $display("FAIL mid_prereset got level=%b want 0", level_a[0]);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({level_a, rise_a, fall_a, pending_a, irq_a} !== 17'h0) begin
      errors++; $display("FAIL mid_reset got=%h want=0", {level_a, rise_a, fall_a, pending_a, irq_a});
    end
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (level_a[0] !== (k >= 18) || rise_a[0] !== (k == 18)) begin
        errors++; $display("FAIL mid_relatch k=%0d got level=%b rise=%b want level=%b rise=%b", k, level_a[0], rise_a[0], k >= 18, k == 18);
      end
    end
  endtask

  task automatic test_bypass();
    logic smp [0:80];
    int   strobes;
    logic expv;
    strobes = 0;
    for (int k = 0; k < 72; k++) begin
      in_b[0] = (k < 64) ? (((k / 4) % 2) == 1) : 1'b1;
      smp[k+1] = in_b[0];
      @(negedge clk);
      expv = (k + 1 > 3) ? smp[k+1-3] : 1'b0;
      checks++;
      if (level_b[0] !== expv) begin
        errors++; $display("FAIL bypass_level e=%0d got=%b want=%b", k + 1, level_b[0], expv);
      end
      checks++;
      if ({level_b, rise_b, fall_b, pending_b, irq_b} !== {m_level[1], m_rise[1], m_fall[1], m_pend[1], |m_pend[1]}
          || {level_b[3:1], rise_b[3:1], fall_b[3:1]} !== 9'h0) begin
        errors++; $display("FAIL bypass_model e=%0d got=%h want=%h", k + 1, {level_b, rise_b, fall_b, pending_b, irq_b}, {m_level[1], m_rise[1], m_fall[1], m_pend[1], |m_pend[1]});
      end
      if (rise_b[0] || fall_b[0]) strobes++;
    end
    checks++;
    if (strobes != 15) begin
      errors++; $display("FAIL bypass_strobes got=%0d want=15", strobes);
    end
  endtask

  task automatic test_random();
    int hold [4];
    reset = 1'b1; ack_a = 4'b0000; ack_b = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) hold[c] = 0;
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          in_a[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 24);
        end else begin
          hold[c] = hold[c] - 1;
        end
      end
      in_b  = 4'($urandom_range(0, 15));
      ack_a = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      ack_b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      @(negedge clk);
      checks++;
      if ({level_a, rise_a, fall_a, pending_a, irq_a} !== {m_level[0], m_rise[0], m_fall[0], m_pend[0], |m_pend[0]}) begin
        errors++; $display("FAIL rand_a k=%0d got=%h want=%h", k, {level_a, rise_a, fall_a, pending_a, irq_a}, {m_level[0], m_rise[0], m_fall[0], m_pend[0], |m_pend[0]});
      end
      checks++;
      if ({level_b, rise_b, fall_b, pending_b, irq_b} !== {m_level[1], m_rise[1], m_fall[1], m_pend[1], |m_pend[1]}) begin
        errors++; $display("FAIL rand_b k=%0d got=%h want=%h", k, {level_b, rise_b, fall_b, pending_b, irq_b}, {m_level[1], m_rise[1], m_fall[1], m_pend[1], |m_pend[1]});
      end
    end
    ack_a = 4'b0000;
    ack_b = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_init_edge();
    test_short_pulse();
    test_bounce();
    test_ack_same_cycle();
    test_reset_midway();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
